block_core_sequencer: RTL and testbench

Sits downstream of word_to_block_assembler and upstream of block_to_word_disassembler. It takes one BSIZE block at a time and issues it to a fixed-latency or variable-latency block core (cipher/hash engine) with a start/done handshake. It holds each result in a two-deep output stage (output register plus stall register) until the downstream stage pulls it. A watchdog aborts core operations that never signal done.

---
 rtl/block_core_sequencer.sv | 112 +++++++++++
 tb/tb_block_core_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_core_sequencer.sv
// rtl/block_core_sequencer.sv - issues assembled blocks to a start/done core and buffers results two deep
// A watchdog drops operations whose core never signals done.
module block_core_sequencer #(
  parameter int BSIZE   = 128,
  parameter int TIMEOUT = 255,
  parameter int TWIDTH  = 8,
  parameter int CWIDTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BSIZE-1:0]  block_in,
  input  logic              block_in_ready,
  output logic              block_in_hold,
  output logic              block_take,
  output logic [BSIZE-1:0]  core_data_out,
  output logic              core_start,
  input  logic              core_done,
  input  logic [BSIZE-1:0]  core_data_in,
  output logic [BSIZE-1:0]  block_out,
  output logic              block_out_ready,
  input  logic              block_out_pull,
  output logic              timeout_err,
  output logic [CWIDTH-1:0] blocks_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STALL} state_t;

  localparam logic [TWIDTH-1:0] WDOG_LAST = TWIDTH'(TIMEOUT - 1);

  state_t            state_q;
  logic [BSIZE-1:0]  core_data_q;
  logic [BSIZE-1:0]  block_out_q;
  logic [BSIZE-1:0]  stall_q;
  logic              block_out_ready_q;
  logic              core_start_q;
  logic              timeout_err_q;
  logic [TWIDTH-1:0] wdog_q;
  logic [CWIDTH-1:0] blocks_done_q;
  logic              out_free;

  assign block_take      = (state_q == S_IDLE) && block_in_ready;
  assign block_in_hold   = (state_q != S_IDLE);
  assign core_data_out   = core_data_q;
  assign core_start      = core_start_q;
  assign block_out       = block_out_q;
  assign block_out_ready = block_out_ready_q;
  assign timeout_err     = timeout_err_q;
  assign blocks_done     = blocks_done_q;

  // A result can go straight to block_out when it is empty or being consumed now
  assign out_free = !block_out_ready_q || block_out_pull;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      core_data_q       <= '0;
      block_out_q       <= '0;
      stall_q           <= '0;
      block_out_ready_q <= 1'b0;
      core_start_q      <= 1'b0;
      timeout_err_q     <= 1'b0;
      wdog_q            <= '0;
      blocks_done_q     <= '0;
    end else begin
      core_start_q <= 1'b0;
      if (block_out_pull && block_out_ready_q) begin
        block_out_ready_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (block_in_ready) begin
            core_data_q  <= block_in;
            core_start_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            blocks_done_q <= blocks_done_q + CWIDTH'(1);
            if (out_free) begin
              block_out_q       <= core_data_in;
              block_out_ready_q <= 1'b1;
              state_q           <= S_IDLE;
            end else begin
              stall_q <= core_data_in;
              state_q <= S_STALL;
            end
          end else if (wdog_q == WDOG_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + TWIDTH'(1);
          end
        end
        S_STALL: begin
          // Stall is only entered with block_out occupied, so ready stays high on reload
          if (block_out_pull) begin
            block_out_q       <= stall_q;
            block_out_ready_q <= 1'b1;
            state_q           <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_core_sequencer.sv
// tb/tb_block_core_sequencer.sv - randomized and directed self-checking bench for block_core_sequencer
module tb_block_core_sequencer;

  localparam int BSIZE   = 128;
  localparam int TIMEOUT = 4;
  localparam int TWIDTH  = 3;
  localparam int CWIDTH  = 8;
  localparam int NRAND   = 60;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [BSIZE-1:0]  block_in = '0;
  logic              block_in_ready = 1'b0;
  logic              block_in_hold;
  logic              block_take;
  logic [BSIZE-1:0]  core_data_out;
  logic              core_start;
  logic              core_done = 1'b0;
  logic [BSIZE-1:0]  core_data_in = '0;
  logic [BSIZE-1:0]  block_out;
  logic              block_out_ready;
  logic              block_out_pull = 1'b0;
  logic              timeout_err;
  logic [CWIDTH-1:0] blocks_done;

  int checks = 0;
  int fails = 0;
  int model_done = 0;

  block_core_sequencer #(
    .BSIZE(BSIZE), .TIMEOUT(TIMEOUT), .TWIDTH(TWIDTH), .CWIDTH(CWIDTH)
  ) dut (
    .clock(clock), .reset(reset),
    .block_in(block_in), .block_in_ready(block_in_ready),
    .block_in_hold(block_in_hold), .block_take(block_take),
    .core_data_out(core_data_out), .core_start(core_start),
    .core_done(core_done), .core_data_in(core_data_in),
    .block_out(block_out), .block_out_ready(block_out_ready),
    .block_out_pull(block_out_pull),
    .timeout_err(timeout_err), .blocks_done(blocks_done)
  );

  always #5 clock = ~clock;

  function automatic logic [BSIZE-1:0] core_fn(input logic [BSIZE-1:0] x);
    return {x[63:0], x[127:64]} ^ {16{8'h3C}};
  endfunction

  function automatic logic [BSIZE-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One block through a well-behaved core answering lat cycles after start
  task automatic xfer(input logic [BSIZE-1:0] d, input int lat);
    block_in = d;
    block_in_ready = 1'b1;
    step();
    block_in_ready = 1'b0;
    repeat (lat) step();
    core_done = 1'b1;
    core_data_in = core_fn(d);
    step();
    core_done = 1'b0;
    model_done++;
  endtask

  task automatic drain_out();
    block_out_pull = 1'b1;
    step();
    step();
    block_out_pull = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (block_out !== '0) begin fails++; $display("FAIL reset_block_out: got %h expected 0", block_out); end
    checks++; if (block_out_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", block_out_ready); end
    checks++; if (core_data_out !== '0) begin fails++; $display("FAIL reset_core_data: got %h expected 0", core_data_out); end
    checks++; if (blocks_done !== '0) begin fails++; $display("FAIL reset_blocks_done: got %0d expected 0", blocks_done); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (core_start !== 1'b0 || block_in_hold !== 1'b0) begin fails++; $display("FAIL reset_start_hold: got %b%b expected 00", core_start, block_in_hold); end
    @(negedge clock);
    reset = 1'b0;
    model_done = 0;
    step();
  endtask

  task automatic test_single();
    logic [BSIZE-1:0] res;
    res = {16{8'hA5}};
    block_in = 128'h00112233445566778899AABBCCDDEEFF;
    block_in_ready = 1'b1;
    #1;
    checks++; if (block_take !== 1'b1) begin fails++; $display("FAIL single_take: got %b expected 1", block_take); end
    step();
    block_in_ready = 1'b0;
    checks++; if (core_start !== 1'b1 || core_data_out !== 128'h00112233445566778899AABBCCDDEEFF) begin fails++; $display("FAIL single_start: got %b %h expected 1 and input block", core_start, core_data_out); end
    step();
    checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %b expected 0", core_start); end
    core_done = 1'b1;
    core_data_in = res;
    step();
    core_done = 1'b0;
    model_done++;
    checks++; if (block_out !== res || block_out_ready !== 1'b1) begin fails++; $display("FAIL single_result: got %h/%b expected %h/1", block_out, block_out_ready, res); end
    checks++; if (blocks_done !== CWIDTH'(model_done)) begin fails++; $display("FAIL single_count: got %0d expected %0d", blocks_done, model_done); end
  endtask

  task automatic test_back_to_back();
    logic [BSIZE-1:0] a, b;
    a = rnd128();
    b = rnd128();
    drain_out();
    xfer(a, 1);
    xfer(b, 1);
    block_in_ready = 1'b1;
    #1;
    checks++; if (block_in_hold !== 1'b1 || block_take !== 1'b0) begin fails++; $display("FAIL b2b_stall_hold: got hold=%b take=%b expected 1 0", block_in_hold, block_take); end
    block_in_ready = 1'b0;
    checks++; if (block_out !== core_fn(a) || block_out_ready !== 1'b1) begin fails++; $display("FAIL b2b_first: got %h/%b expected %h/1", block_out, block_out_ready, core_fn(a)); end
    block_out_pull = 1'b1;
    step();
    block_out_pull = 1'b0;
    checks++; if (block_out !== core_fn(b) || block_out_ready !== 1'b1 || block_in_hold !== 1'b0) begin fails++; $display("FAIL b2b_second: got %h/%b hold=%b expected %h/1 hold=0", block_out, block_out_ready, block_in_hold, core_fn(b)); end
    block_out_pull = 1'b1;
    step();
    block_out_pull = 1'b0;
    checks++; if (block_out_ready !== 1'b0 || block_out !== core_fn(b)) begin fails++; $display("FAIL b2b_empty: got %h/%b expected %h/0", block_out, block_out_ready, core_fn(b)); end
    checks++; if (blocks_done !== CWIDTH'(model_done)) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", blocks_done, model_done); end
  endtask

  task automatic test_done_pull_same();
    logic [BSIZE-1:0] a, b;
    a = rnd128();
    b = rnd128();
    drain_out();
    xfer(a, 1);
    block_in = b;
    block_in_ready = 1'b1;
    step();
    block_in_ready = 1'b0;
    step();
    core_done = 1'b1;
    core_data_in = core_fn(b);
    block_out_pull = 1'b1;
    step();
    core_done = 1'b0;
    block_out_pull = 1'b0;
    model_done++;
    checks++; if (block_out !== core_fn(b) || block_out_ready !== 1'b1) begin fails++; $display("FAIL done_pull_load: got %h/%b expected %h/1", block_out, block_out_ready, core_fn(b)); end
    checks++; if (block_in_hold !== 1'b0) begin fails++; $display("FAIL done_pull_nostall: got hold=%b expected 0", block_in_hold); end
  endtask

  task automatic test_spurious();
    logic [BSIZE-1:0] p, d;
    p = rnd128();
    d = rnd128();
    block_out_pull = 1'b1;
    xfer(p, 1);
    block_out_pull = 1'b0;
    core_done = 1'b1;
    core_data_in = rnd128();
    step();
    core_done = 1'b0;
    checks++; if (blocks_done !== CWIDTH'(model_done) || block_out !== core_fn(p)) begin fails++; $display("FAIL spurious_idle: got %0d %h expected %0d %h", blocks_done, block_out, model_done, core_fn(p)); end
    block_in = d;
    block_in_ready = 1'b1;
    step();
    block_in_ready = 1'b0;
    core_done = 1'b1;
    core_data_in = rnd128();
    step();
    core_done = 1'b0;
    checks++; if (blocks_done !== CWIDTH'(model_done) || block_out !== core_fn(p)) begin fails++; $display("FAIL spurious_issue: got %0d %h expected %0d %h", blocks_done, block_out, model_done, core_fn(p)); end
    core_done = 1'b1;
    core_data_in = core_fn(d);
    block_out_pull = 1'b1;
    step();
    core_done = 1'b0;
    block_out_pull = 1'b0;
    model_done++;
    checks++; if (blocks_done !== CWIDTH'(model_done) || block_out !== core_fn(d)) begin fails++; $display("FAIL spurious_real: got %0d %h expected %0d %h", blocks_done, block_out, model_done, core_fn(d)); end
  endtask

  task automatic test_timeout();
    logic [BSIZE-1:0] k, d;
    int n;
    k = rnd128();
    d = rnd128();
    drain_out();
    xfer(k, 1);
    block_in = rnd128();
    block_in_ready = 1'b1;
    step();
    block_in_ready = 1'b0;
    n = 0;
    while (n < 20 && timeout_err !== 1'b1) begin
      step();
      n++;
    end
    // WAIT spans TIMEOUT cycles; the flag appears the cycle after the last one
    checks++; if (n != TIMEOUT + 1) begin fails++; $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TIMEOUT + 1); end
    checks++; if (block_in_hold !== 1'b0 || block_out_ready !== 1'b1 || block_out !== core_fn(k)) begin fails++; $display("FAIL timeout_state: got hold=%b ready=%b out=%h expected 0 1 %h", block_in_hold, block_out_ready, block_out, core_fn(k)); end
    checks++; if (blocks_done !== CWIDTH'(model_done)) begin fails++; $display("FAIL timeout_count: got %0d expected %0d", blocks_done, model_done); end
    block_out_pull = 1'b1;
    xfer(d, TIMEOUT);
    block_out_pull = 1'b0;
    checks++; if (block_out !== core_fn(d) || block_out_ready !== 1'b1 || timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_next: got %h/%b err=%b expected %h/1 err=1", block_out, block_out_ready, timeout_err, core_fn(d)); end
  endtask

  task automatic test_reset_midop();
    drain_out();
    xfer(rnd128(), 1);
    block_in = rnd128();
    block_in_ready = 1'b1;
    step();
    block_in_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++; if (block_out !== '0 || block_out_ready !== 1'b0 || core_data_out !== '0) begin fails++; $display("FAIL midop_data: got %h/%b/%h expected zeros", block_out, block_out_ready, core_data_out); end
    checks++; if (blocks_done !== '0 || timeout_err !== 1'b0 || block_in_hold !== 1'b0 || core_start !== 1'b0) begin fails++; $display("FAIL midop_ctrl: got cnt=%0d err=%b hold=%b start=%b expected all 0", blocks_done, timeout_err, block_in_hold, core_start); end
    model_done = 0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL midop_no_start: got %b expected 0 at cycle %0d", core_start, i); end
    end
    block_out_pull = 1'b1;
    xfer(rnd128(), 1);
    block_out_pull = 1'b0;
    checks++; if (blocks_done !== CWIDTH'(model_done)) begin fails++; $display("FAIL midop_recover: got %0d expected %0d", blocks_done, model_done); end
  endtask

  task automatic test_wrap();
    int n;
    n = (1 << CWIDTH) - (model_done % (1 << CWIDTH));
    block_out_pull = 1'b1;
    for (int i = 0; i < n - 1; i++) xfer(rnd128(), 1);
    checks++; if (blocks_done !== CWIDTH'((1 << CWIDTH) - 1)) begin fails++; $display("FAIL wrap_max: got %0d expected %0d", blocks_done, (1 << CWIDTH) - 1); end
    xfer(rnd128(), 1);
    checks++; if (blocks_done !== '0) begin fails++; $display("FAIL wrap_zero: got %0d expected 0", blocks_done); end
    xfer(rnd128(), 1);
    checks++; if (blocks_done !== CWIDTH'(1)) begin fails++; $display("FAIL wrap_one: got %0d expected 1", blocks_done); end
    block_out_pull = 1'b0;
  endtask

  // Transaction model: in-order results, drops when core latency exceeds TIMEOUT
  task automatic test_random();
    logic [BSIZE-1:0] issued[$];
    logic [BSIZE-1:0] expect_q[$];
    logic [BSIZE-1:0] pend_data, d;
    int pend_rem, sent, lat, cyc, exp_done;
    bit pending, exp_err;
    pending = 0; sent = 0; cyc = 0; exp_done = 0; exp_err = 0; pend_rem = 0;
    pend_data = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    step();
    while (cyc < 3000) begin
      if (sent == NRAND && !pending && issued.size() == 0 && expect_q.size() == 0
          && !block_out_ready && !block_in_hold) break;
      core_done = 1'b0;
      if (pending) begin
        pend_rem--;
        if (pend_rem == 0) begin
          core_done = 1'b1;
          core_data_in = core_fn(pend_data);
          pending = 0;
        end
      end
      if (core_start) begin
        checks++;
        if (issued.size() == 0) begin fails++; $display("FAIL rand_start: unexpected core_start at cycle %0d", cyc); end
        else begin
          d = issued.pop_front();
          if (core_data_out !== d) begin fails++; $display("FAIL rand_core_data: got %h expected %h", core_data_out, d); end
        end
        pend_data = core_data_out;
        lat = $urandom_range(1, TIMEOUT + 2);
        pend_rem = lat;
        pending = 1;
        if (lat <= TIMEOUT) begin
          expect_q.push_back(core_fn(pend_data));
          exp_done++;
        end else exp_err = 1;
      end
      block_out_pull = ($urandom_range(0, 1) == 1);
      if (block_out_pull && block_out_ready) begin
        checks++;
        if (expect_q.size() == 0) begin fails++; $display("FAIL rand_extra_out: got %h expected nothing", block_out); end
        else begin
          d = expect_q.pop_front();
          if (block_out !== d) begin fails++; $display("FAIL rand_out: got %h expected %h", block_out, d); end
        end
      end
      block_in_ready = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      block_in = rnd128();
      #1;
      checks++;
      if (block_take !== (block_in_ready && !block_in_hold)) begin fails++; $display("FAIL rand_take: got %b expected %b", block_take, block_in_ready && !block_in_hold); end
      if (block_take) begin
        issued.push_back(block_in);
        sent++;
      end
      step();
      cyc++;
    end
    core_done = 1'b0;
    block_in_ready = 1'b0;
    block_out_pull = 1'b0;
    checks++; if (cyc >= 3000) begin fails++; $display("FAIL rand_bound: got %0d cycles expected under 3000", cyc); end
    checks++; if (blocks_done !== CWIDTH'(exp_done)) begin fails++; $display("FAIL rand_count: got %0d expected %0d", blocks_done, exp_done); end
    checks++; if (timeout_err !== exp_err) begin fails++; $display("FAIL rand_timeout_err: got %b expected %b", timeout_err, exp_err); end
    checks++; if (expect_q.size() != 0) begin fails++; $display("FAIL rand_leftover: got %0d results unread expected 0", expect_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_done_pull_same();
    test_spurious();
    test_timeout();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
